// File: rtl/udma_eth_tx_framer_if.sv
// udma_eth_tx_framer_if
//   Handshake bundle around the eth-side TX framer.
//   - length descriptor : len_data_i / len_valid_i / len_ready_o
//   - payload bytes     : data_i / data_valid_i / data_ready_o
//   - AXI-Stream to MAC : m_axis_tdata_o / tvalid_o / tready_i / tlast_o / tuser_o
//   master : the side feeding descriptors and bytes and sinking the stream (FIFOs + MAC)
//   slave  : the framer itself
//   Signal names keep the framer's _i/_o view so they read the same at both ends.
interface udma_eth_tx_framer_if #(
   parameter int LEN_WIDTH = 11
);
   logic [LEN_WIDTH-1:0] len_data_i;
   logic                 len_valid_i;
   logic                 len_ready_o;
   logic [7:0]           data_i;
   logic                 data_valid_i;
   logic                 data_ready_o;
   logic [7:0]           m_axis_tdata_o;
   logic                 m_axis_tvalid_o;
   logic                 m_axis_tready_i;
   logic                 m_axis_tlast_o;
   logic                 m_axis_tuser_o;

   modport master (
      output len_data_i, len_valid_i, data_i, data_valid_i, m_axis_tready_i,
      input  len_ready_o, data_ready_o, m_axis_tdata_o, m_axis_tvalid_o,
             m_axis_tlast_o, m_axis_tuser_o
   );

   modport slave (
      input  len_data_i, len_valid_i, data_i, data_valid_i, m_axis_tready_i,
      output len_ready_o, data_ready_o, m_axis_tdata_o, m_axis_tvalid_o,
             m_axis_tlast_o, m_axis_tuser_o
   );
endinterface

// File: rtl/udma_eth_tx_framer.sv
// udma_eth_tx_framer
//   Eth-clock TX framer: takes a length descriptor and a byte stream (both from
//   the dst side of dual-clock FIFOs) and emits one AXI-Stream frame to the MAC.
//   Generates tlast from the length, enforces the inter-frame gap, rejects
//   zero/oversize lengths (bytes flushed) and aborts a starved frame with a
//   tuser-marked 0x00 tlast beat.
// Ports:
//   eth_clk_i, eth_rstn_i  clock, asynchronous active-low reset
//   bus (slave)            descriptor, payload and AXIS handshakes
//   tx_done_o              1-cycle pulse, good frame completed
//   tx_error_o             1-cycle pulse, illegal length or underrun abort
//   busy_o                 high whenever not IDLE
// Build option:
//   ETH_TX_PAD_EN          when defined, short frames are padded with 0x00 beats
//                          up to MIN_LEN bytes (PAD state); otherwise frames are
//                          exactly L bytes and MIN_LEN is not used for padding.
module udma_eth_tx_framer #(
   parameter int LEN_WIDTH       = 11,
   parameter int MAX_LEN         = 1518,
   parameter int MIN_LEN         = 60,
   parameter int IFG_CYCLES      = 12,
   parameter int UNDERRUN_CYCLES = 256
) (
   input  logic                  eth_clk_i,
   input  logic                  eth_rstn_i,
   udma_eth_tx_framer_if.slave   bus,
   output logic                  tx_done_o,
   output logic                  tx_error_o,
   output logic                  busy_o
);

   localparam int UC_W = ($clog2(UNDERRUN_CYCLES) > 0) ? $clog2(UNDERRUN_CYCLES) : 1;
   localparam int GC_W = ($clog2(IFG_CYCLES) > 0) ? $clog2(IFG_CYCLES) : 1;
   // A pad minimum above MAX_LEN would make every padded frame illegal; the
   // larger of the two is taken as the length ceiling.
   localparam int LEN_LIMIT = (MIN_LEN > MAX_LEN) ? MIN_LEN : MAX_LEN;

   localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(LEN_LIMIT);
   localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);
   localparam logic [UC_W-1:0]      UC_MAX  = UC_W'(UNDERRUN_CYCLES - 1);
   localparam logic [GC_W-1:0]      GC_LAST = GC_W'(IFG_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STREAM = 3'd1,
      ABORT  = 3'd2,   // abort beat loaded, waiting for its handshake
      FLUSH  = 3'd3,
`ifdef ETH_TX_PAD_EN
      PAD    = 3'd5,
`endif
      GAP    = 3'd4
   } state_t;

   state_t               state_q;
   logic [LEN_WIDTH-1:0] rem_q;
   logic [LEN_WIDTH-1:0] sent_q;
   logic [UC_W-1:0]      uc_q;
   logic [GC_W-1:0]      gap_q;
   logic [7:0]           tdata_q;
   logic                 tvalid_q, tlast_q, tuser_q;
   logic                 done_q, err_q;
   logic                 run_q;   // keeps len_ready_o low while in reset

   logic out_free, len_acc, data_acc, beat_hs, data_rdy;

`ifdef ETH_TX_PAD_EN
   localparam logic [LEN_WIDTH:0] MIN_L = (LEN_WIDTH+1)'(MIN_LEN);
   logic [LEN_WIDTH:0] sent_nxt;
   logic               pad_need;
   assign sent_nxt = {1'b0, sent_q} + (LEN_WIDTH+1)'(1);
   assign pad_need = sent_nxt < MIN_L;
`endif

   assign out_free = !tvalid_q || bus.m_axis_tready_i;
   assign data_rdy = ((state_q == STREAM) && (rem_q != '0) && out_free) ||
                     ((state_q == FLUSH) && (rem_q != '0));
   assign len_acc  = bus.len_valid_i && bus.len_ready_o;
   assign data_acc = bus.data_valid_i && data_rdy;
   assign beat_hs  = tvalid_q && bus.m_axis_tready_i;

   assign bus.len_ready_o     = run_q && (state_q == IDLE);
   assign bus.data_ready_o    = data_rdy;
   assign bus.m_axis_tdata_o  = tdata_q;
   assign bus.m_axis_tvalid_o = tvalid_q;
   assign bus.m_axis_tlast_o  = tlast_q;
   assign bus.m_axis_tuser_o  = tuser_q;
   assign tx_done_o           = done_q;
   assign tx_error_o          = err_q;
   assign busy_o              = (state_q != IDLE);

   always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
      if (!eth_rstn_i) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         sent_q   <= '0;
         uc_q     <= '0;
         gap_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         run_q  <= 1'b1;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // Beat leaves the output register; any load below overrides this.
         if (beat_hs) tvalid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (len_acc) begin
                  if (bus.len_data_i == '0) begin
                     err_q <= 1'b1;
                  end else if (bus.len_data_i > MAX_L) begin
                     err_q   <= 1'b1;
                     rem_q   <= bus.len_data_i;
                     state_q <= FLUSH;
                  end else begin
                     rem_q   <= bus.len_data_i;
                     sent_q  <= '0;
                     uc_q    <= '0;
                     state_q <= STREAM;
                  end
               end
            end

            STREAM: begin
               if (data_acc) begin
                  tdata_q  <= bus.data_i;
                  tvalid_q <= 1'b1;
                  tuser_q  <= 1'b0;
                  rem_q    <= rem_q - ONE;
                  sent_q   <= sent_q + ONE;
                  uc_q     <= '0;
`ifdef ETH_TX_PAD_EN
                  tlast_q  <= (rem_q == ONE) && !pad_need;
                  if ((rem_q == ONE) && pad_need) state_q <= PAD;
`else
                  tlast_q  <= (rem_q == ONE);
`endif
               end else if ((rem_q != '0) && !bus.data_valid_i) begin
                  // Byte accept above has priority over the abort.
                  if ((uc_q == UC_MAX) && out_free) begin
                     tdata_q  <= 8'h00;
                     tvalid_q <= 1'b1;
                     tlast_q  <= 1'b1;
                     tuser_q  <= 1'b1;
                     err_q    <= 1'b1;
                     uc_q     <= '0;
                     state_q  <= ABORT;
                  end else if (uc_q != UC_MAX) begin
                     uc_q <= uc_q + UC_W'(1);
                  end
               end
               // rem is 0 here, so no byte can be loaded on this cycle.
               if (beat_hs && tlast_q && !tuser_q) begin
                  done_q  <= 1'b1;
                  gap_q   <= '0;
                  state_q <= GAP;
               end
            end

            ABORT: begin
               if (beat_hs) begin
                  gap_q   <= '0;
                  state_q <= (rem_q == '0) ? GAP : FLUSH;
               end
            end

            FLUSH: begin
               if (data_acc) begin
                  rem_q <= rem_q - ONE;
                  if (rem_q == ONE) begin
                     gap_q   <= '0;
                     state_q <= GAP;
                  end
               end
            end

`ifdef ETH_TX_PAD_EN
            PAD: begin
               if (tvalid_q && tlast_q) begin
                  if (bus.m_axis_tready_i) begin
                     done_q  <= 1'b1;
                     gap_q   <= '0;
                     state_q <= GAP;
                  end
               end else if (out_free) begin
                  tdata_q  <= 8'h00;
                  tvalid_q <= 1'b1;
                  tuser_q  <= 1'b0;
                  tlast_q  <= (sent_nxt == MIN_L);
                  sent_q   <= sent_q + ONE;
               end
            end
`endif

            GAP: begin
               if (gap_q == GC_LAST) state_q <= IDLE;
               else                  gap_q   <= gap_q + GC_W'(1);
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udma_eth_tx_framer.sv
// Directed, table-driven bench for udma_eth_tx_framer: each record gives a
// descriptor, source/sink behaviour and the expected frame outcome.
module tb_udma_eth_tx_framer;
   localparam int LW = 11;
`ifdef ETH_TX_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   typedef struct {
      int len;    // descriptor
      int nsup;   // bytes the source offers
      int tr;     // 0: tready=1, 1: tready toggles
      int src;    // 0: always valid, 1: random gaps, 2: starve 300 cycles after 5 bytes
      int base;   // payload byte k = base+k
      int pay;    // payload beats expected on the stream
      int abrt;   // abort beat expected
      int done;   // tx_done pulses expected
      int err;    // tx_error pulses expected
      int cons;   // bytes expected consumed
   } vec_t;

   logic eth_clk_i  = 1'b0;
   logic eth_rstn_i = 1'b0;
   logic tx_done_o, tx_error_o, busy_o;
   int   checks = 0;
   int   errors = 0;
   vec_t vt[11];

   udma_eth_tx_framer_if #(.LEN_WIDTH(LW)) bus ();

   udma_eth_tx_framer #(
      .LEN_WIDTH(LW), .MAX_LEN(1518), .MIN_LEN(60),
      .IFG_CYCLES(12), .UNDERRUN_CYCLES(256)
   ) dut (
      .eth_clk_i  (eth_clk_i),
      .eth_rstn_i (eth_rstn_i),
      .bus        (bus),
      .tx_done_o  (tx_done_o),
      .tx_error_o (tx_error_o),
      .busy_o     (busy_o)
   );

   always #4 eth_clk_i = ~eth_clk_i;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.len_valid_i     = 1'b0;
      bus.len_data_i      = '0;
      bus.data_valid_i    = 1'b0;
      bus.data_i          = 8'h00;
      bus.m_axis_tready_i = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      logic [7:0] bd[$];
      bit         bl[$], bu[$];
      int  idx = 0, ncons = 0, ndone = 0, nerr = 0, nboth = 0, nstab = 0;
      int  gap = 0, stall = 0, budget, last_acc = -1, abort_at = -1, last_hs = -1, done_at = -1;
      int  pad, eb, nbad = 0, bad_i = -1;
      bit  lacc = 0, gap_on = 0, gap_end = 0, fin = 0;
      logic pv = 0, pr = 0, pl = 0, pu = 0;
      logic [7:0] pd = 0;
      logic [7:0] ed;
      bit el, eu;

      budget = 3 * v.nsup + 1200;
      bus.len_data_i = LW'(v.len);
      for (int n = 0; n < budget && !fin; n++) begin
         @(negedge eth_clk_i);
         bus.len_valid_i     = !lacc;
         bus.m_axis_tready_i = (v.tr == 1) ? n[0] : 1'b1;
         bus.data_valid_i    = 1'b0;
         if (idx < v.nsup) begin
            case (v.src)
               1:       bus.data_valid_i = ($urandom_range(0, 2) != 0);
               2:       if (idx == 5 && stall < 300) stall++;
                        else bus.data_valid_i = 1'b1;
               default: bus.data_valid_i = 1'b1;
            endcase
         end
         bus.data_i = 8'(v.base + idx);
         #1;
         if (tx_done_o) begin ndone++; done_at = n; gap_on = 1; end
         if (tx_error_o) nerr++;
         if (tx_done_o && tx_error_o) nboth++;
         if (gap_on && !gap_end) begin
            if (bus.len_ready_o) gap_end = 1; else gap++;
         end
         if (pv && !pr && !(bus.m_axis_tvalid_o && bus.m_axis_tdata_o == pd &&
                            bus.m_axis_tlast_o == pl && bus.m_axis_tuser_o == pu)) nstab++;
         if (bus.m_axis_tvalid_o && bus.m_axis_tuser_o && abort_at < 0) abort_at = n;
         if (bus.m_axis_tvalid_o && bus.m_axis_tready_i) begin
            bd.push_back(bus.m_axis_tdata_o);
            bl.push_back(bus.m_axis_tlast_o);
            bu.push_back(bus.m_axis_tuser_o);
            last_hs = n;
         end
         if (bus.data_valid_i && bus.data_ready_o) begin
            idx++; ncons++;
            if (abort_at < 0) last_acc = n;
         end
         if (lacc && !busy_o && !bus.m_axis_tvalid_o && idx == v.nsup) fin = 1;
         if (bus.len_valid_i && bus.len_ready_o) lacc = 1;
         pv = bus.m_axis_tvalid_o; pr = bus.m_axis_tready_i; pd = bus.m_axis_tdata_o;
         pl = bus.m_axis_tlast_o;  pu = bus.m_axis_tuser_o;
      end
      @(negedge eth_clk_i);
      idle_inputs();

      pad = (PAD && v.done != 0 && v.pay < 60) ? 60 - v.pay : 0;
      eb  = v.pay + v.abrt + pad;
      chk({tag, "_finished"}, fin, 1);
      chk({tag, "_beats"}, bd.size(), eb);
      for (int i = 0; i < bd.size() && i < eb; i++) begin
         ed = (i < v.pay) ? 8'(v.base + i) : 8'h00;
         el = (i == eb - 1);
         eu = (v.abrt != 0) && (i == eb - 1);
         if (bd[i] != ed || bl[i] != el || bu[i] != eu) begin
            nbad++;
            if (bad_i < 0) begin
               bad_i = i;
               $display("  %s beat %0d: actual %02h/%0b/%0b required %02h/%0b/%0b",
                        tag, i, bd[i], bl[i], bu[i], ed, el, eu);
            end
         end
      end
      chk({tag, "_beat_content"}, nbad, 0);
      chk({tag, "_done"}, ndone, v.done);
      chk({tag, "_error"}, nerr, v.err);
      chk({tag, "_consumed"}, ncons, v.cons);
      chk({tag, "_done_err_overlap"}, nboth, 0);
      chk({tag, "_hold_while_stalled"}, nstab, 0);
      if (v.done != 0) begin
         chk({tag, "_done_latency"}, done_at - last_hs, 1);
         chk({tag, "_ifg_cycles"}, gap, 12);
      end
      if (v.abrt != 0) chk({tag, "_abort_latency"}, abort_at - last_acc, 257);
   endtask

   initial begin
      int nb, idx;
      bit lacc;
      vec_t vr;

      //            len  nsup tr src base  pay abrt done err cons
      vt[0]  = '{   4,    4, 0, 0, 'hA0,   4, 0, 1, 0,    4};
      vt[1]  = '{   8,    8, 1, 1, 'h10,   8, 0, 1, 0,    8};
      vt[2]  = '{   0,    0, 0, 0, 'h00,   0, 0, 0, 1,    0};
      vt[3]  = '{1600, 1600, 0, 0, 'h00,   0, 0, 0, 1, 1600};
      vt[4]  = '{  10,   10, 0, 2, 'h30,   5, 1, 0, 1,   10};
      vt[5]  = '{   3,    3, 0, 0, 'h50,   3, 0, 1, 0,    3};
      vt[6]  = '{  20,   20, 1, 0, 'h60,  20, 0, 1, 0,   20};
      vt[7]  = '{1518, 1518, 0, 0, 'h05,1518, 0, 1, 0, 1518};
      vt[8]  = '{1519, 1519, 0, 0, 'h00,   0, 0, 0, 1, 1519};
      vt[9]  = '{   1,    1, 0, 0, 'hC0,   1, 0, 1, 0,    1};
      vt[10] = '{   2,    2, 0, 0, 'hE0,   2, 0, 1, 0,    2};

      idle_inputs();
      #10;
      chk("reset_outputs", longint'({bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.m_axis_tuser_o,
                                     bus.m_axis_tdata_o != 8'h00, tx_done_o, tx_error_o, busy_o,
                                     bus.len_ready_o, bus.data_ready_o}), 0);
      @(negedge eth_clk_i);
      eth_rstn_i = 1'b1;
      @(negedge eth_clk_i);
      @(negedge eth_clk_i);
      chk("idle_len_ready", bus.len_ready_o, 1);
      chk("idle_busy", busy_o, 0);

      for (int k = 0; k < 10; k++) run_frame(vt[k], $sformatf("v%0d", k));

      // Reset in the middle of an L=10 frame, after three beats.
      nb = 0; idx = 0; lacc = 0;
      bus.len_data_i = LW'(10);
      for (int n = 0; n < 100 && nb < 3; n++) begin
         @(negedge eth_clk_i);
         bus.len_valid_i     = !lacc;
         bus.m_axis_tready_i = 1'b1;
         bus.data_valid_i    = 1'b1;
         bus.data_i          = 8'(8'h70 + idx);
         #1;
         if (bus.len_valid_i && bus.len_ready_o) lacc = 1;
         if (bus.data_valid_i && bus.data_ready_o) idx++;
         if (bus.m_axis_tvalid_o && bus.m_axis_tready_i) nb++;
      end
      chk("midrst_beats_before", nb, 3);
      @(negedge eth_clk_i);
      chk("midrst_busy_before", busy_o, 1);
      eth_rstn_i = 1'b0;
      #1;
      chk("midrst_outputs", longint'({bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.m_axis_tuser_o,
                                      bus.m_axis_tdata_o != 8'h00, tx_done_o, tx_error_o, busy_o,
                                      bus.len_ready_o, bus.data_ready_o}), 0);
      idle_inputs();
      repeat (3) @(negedge eth_clk_i);
      eth_rstn_i = 1'b1;
      @(negedge eth_clk_i);
      vr = vt[10];
      run_frame(vr, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/udma_eth_tx_framer.md
Name: udma_eth_tx_framer

Overview:
- Eth-clock-domain transmit framer. Turns a per-packet length descriptor plus a uDMA TX byte stream into an AXI-Stream byte frame for the Ethernet MAC.
- Both inputs arrive already in the eth_clk_i domain, from the dst side of the length and data dual-clock FIFOs.
- Generates tlast from the length, enforces the inter-frame gap, rejects illegal lengths, and aborts frames on source underrun.
- Completion and error pulses go to the sys-side event synchroniser.

Parameters:
LEN_WIDTH, 11, width of length descriptor and byte counters
MAX_LEN, 1518, largest legal frame length in bytes
MIN_LEN, 60, minimum frame length used when padding is enabled
IFG_CYCLES, 12, idle cycles enforced after each frame's last beat
UNDERRUN_CYCLES, 256, starvation cycles mid-frame before abort

Ports:
eth_clk_i  in  1  125 MHz Ethernet clock
eth_rstn_i  in  1  asynchronous active-low reset
len_data_i  in  LEN_WIDTH  frame length in bytes
len_valid_i  in  1  length descriptor valid
len_ready_o  out  1  length descriptor accept
data_i  in  8  TX payload byte
data_valid_i  in  1  payload byte valid
data_ready_o  out  1  payload byte accept
m_axis_tdata_o  out  8  byte to MAC
m_axis_tvalid_o  out  1  beat valid
m_axis_tready_i  in  1  MAC ready
m_axis_tlast_o  out  1  last beat of frame
m_axis_tuser_o  out  1  frame-bad marker (valid with tlast)
tx_done_o  out  1  one-cycle pulse: good frame completed
tx_error_o  out  1  one-cycle pulse: illegal length or underrun abort
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: eth_rstn_i is asynchronous, active-low; the block is clocked on eth_clk_i. All outputs reset to 0, all counters to 0, state to IDLE.
- Reset mid-frame: the partial frame is dropped without tlast. The MAC relies on its own reset for that case.
- Handshakes: a transfer occurs when valid and ready are both high on a rising edge.
  - Once m_axis_tvalid_o is high, tdata, tlast and tuser hold stable until tready.
- Output register: a single stage. data_ready_o = (state==STREAM) && rem>0 && (!m_axis_tvalid_o || m_axis_tready_i), driven combinationally.
  - Latency is 1 cycle from byte accept to m_axis_tvalid_o.
  - With continuous tready=1 the throughput is 1 byte/cycle.
- IDLE:
  - len_ready_o=1 only in IDLE.
  - On descriptor accept, L=len_data_i.
  - If L==0: tx_error_o pulses; the state stays IDLE.
  - If L>MAX_LEN: tx_error_o pulses; rem=L; go to FLUSH.
  - Otherwise: rem=L, sent=0; go to STREAM.
- STREAM:
  - Each accepted byte is loaded into the output register; rem decrements and sent increments.
  - tlast=1 on the byte where rem==1, provided no padding is required.
  - On the tlast handshake with tuser=0: tx_done_o pulses; go to GAP.
- Underrun:
  - The counter uc increments each STREAM cycle with rem>0 and data_valid_i=0. It clears on any byte accept.
  - When uc==UNDERRUN_CYCLES-1 and the output register is free, load the abort beat: tdata=0x00, tlast=1, tuser=1. tx_error_o pulses on the load cycle.
  - After the abort beat handshakes, go to FLUSH with rem unchanged, or to GAP if rem==0.
- FLUSH:
  - data_ready_o=1. rem bytes are discarded; no AXIS beats are produced.
  - Go to GAP when rem reaches 0.
- GAP: all outputs idle for IFG_CYCLES cycles, then return to IDLE.
- Simultaneous events:
  - A byte arriving on the same cycle the underrun threshold is reached is accepted and the abort is cancelled. Byte accept has priority.
  - tx_done_o and tx_error_o are never asserted together.
- Width rules:
  - Counters are LEN_WIDTH bits and never wrap, since L<=2^LEN_WIDTH-1.
  - The uc counter is clog2(UNDERRUN_CYCLES) bits and saturates.

Optional Feature:
- Macro: ETH_TX_PAD_EN.
- Defined: PAD state added.
  - When rem hits 0 and sent<MIN_LEN, tlast is not set on the last payload byte.
  - PAD then emits 0x00 beats until sent==MIN_LEN, with tlast on the final pad beat.
  - data_ready_o=0 in PAD.
  - tx_done_o pulses after the pad tlast.
- Undefined: frames are emitted at exactly L bytes, and the PAD state and MIN_LEN logic are absent. MIN_LEN is then ignored.

Test Plan:
- L=4, bytes A0..A3 back-to-back, tready=1 -> 4 beats A0..A3; tlast only on A3; tx_done_o 1 cycle after the A3 handshake; len_ready_o low for 12 cycles after that.
- L=8, tready toggling 1010..., source with random gaps -> exactly 8 beats in order, no duplication; tdata stable while tvalid && !tready.
- L=0 -> tx_error_o one pulse, no beats, back to IDLE. L=1600 with 1600 bytes supplied -> tx_error_o, all 1600 bytes consumed, zero beats, then GAP.
- L=10, 5 bytes then starve -> 256 cycles after the 5th accept, a beat 0x00 with tlast=1, tuser=1 and tx_error_o. The next 5 bytes are discarded. A following L=3 frame is sent cleanly.
- Padding, L=20:
  - With ETH_TX_PAD_EN: 60 beats, beats 21..60 = 0x00, tlast on beat 60, tx_done_o once.
  - Without: 20 beats, tlast on beat 20.
- eth_rstn_i asserted after 3 beats of an L=10 frame -> all outputs 0 immediately. After release, a new L=2 frame completes normally.
